snake_cmd_mailbox: RTL

- Parametrised successor to the single-channel snake command/state conduit.
- Avalon-MM slave on the HPS lightweight bridge. Holds a per-channel command FIFO that feeds game logic in the fabric over a valid/ready handshake.
- Registers per-channel game-state words for readback and raises an interrupt when any state changes.
- Owns a software-controlled game reset output.

---
 rtl/snake_ctrl_pkg.sv | 29 ++
 rtl/snake_cmd_fifo.sv | 71 +++++++
 rtl/snake_cmd_mailbox.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/snake_ctrl_pkg.sv
// Shared constants for the snake command mailbox.
//   - Register word addresses on the Avalon-MM slave
//   - CTRL register bit positions
//   - Field offsets inside CMD and STATUS words
//   - status_word(): packs the per-channel flag vectors into the STATUS layout
package snake_ctrl_pkg;

  localparam logic [3:0] ADDR_CMD    = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_CTRL   = 4'd2;
  localparam logic [3:0] ADDR_IRQ    = 4'd3;
  localparam logic [3:0] ADDR_STATE0 = 4'd4;

  localparam int CTRL_GAME_RST_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;

  localparam int CMD_CH_LSB      = 8;
  localparam int CMD_CH_WIDTH    = 4;
  localparam int STATUS_FULL_LSB = 8;
  localparam int STATUS_OVF_LSB  = 16;

  // Empty flags in [7:0], full flags in [15:8], overflow flags in [23:16].
  function automatic logic [31:0] status_word(input logic [7:0] empty,
                                              input logic [7:0] full,
                                              input logic [7:0] ovf);
    return {8'd0, ovf, full, empty};
  endfunction

endpackage

// File: rtl/snake_cmd_fifo.sv
// Per-channel command FIFO with show-ahead head output.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   flush       - synchronous clear; holds the FIFO empty while high
//   push/push_data - write request; accepted when not full or when popping
//   pop         - advance head; ignored when empty
//   head        - storage word at the read pointer (valid only when !empty)
//   empty, full - occupancy flags derived from the entry count
module snake_cmd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty     = (count_q == CW'(0));
  assign full      = (count_q == CW'(DEPTH));
  assign head      = mem_q[rd_ptr_q];
  assign do_pop_s  = pop & ~empty & ~flush;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push_s = push & (~full | do_pop_s) & ~flush;

  // Next entry count from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/snake_cmd_mailbox.sv
// HPS lightweight-bridge mailbox between software and NUM_CH game channels.
// Ports:
//   clk, reset                  - system clock, asynchronous active-high reset
//   avs_*                       - Avalon-MM slave, 1-cycle registered read data
//   irq                         - level interrupt: irq_en & any pending state change
//   cmd_data/cmd_valid/cmd_ready - per-channel show-ahead command stream
//   state_in                    - per-channel game state, sampled every cycle
//   game_reset_n                - software-controlled active-low game reset
module snake_cmd_mailbox
  import snake_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CMD_WIDTH   = 7,
  parameter int STATE_WIDTH = 7,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    avs_address,
  input  logic                          avs_read,
  input  logic                          avs_write,
  input  logic [31:0]                   avs_writedata,
  output logic [31:0]                   avs_readdata,
  output logic                          irq,
  output logic [NUM_CH*CMD_WIDTH-1:0]   cmd_data,
  output logic [NUM_CH-1:0]             cmd_valid,
  input  logic [NUM_CH-1:0]             cmd_ready,
  input  logic [NUM_CH*STATE_WIDTH-1:0] state_in,
  output logic                          game_reset_n
);

  logic [NUM_CH-1:0]      fifo_empty_s, fifo_full_s, push_s, pop_s;
  logic [CMD_WIDTH-1:0]   head_s [NUM_CH];
  logic [NUM_CH-1:0]      ovf_q, ovf_d, pend_q, pend_d;
  logic [1:0]             ctrl_q, ctrl_d;
  logic [STATE_WIDTH-1:0] state_q [NUM_CH];
  logic                   primed_q;
  logic [31:0]            rdata_q, rd_mux_s;
  logic                   irq_q, game_reset_n_q;
  logic                   game_rst_s, wr_cmd_s;
  logic [CMD_CH_WIDTH-1:0] cmd_ch_s;
  logic                   unused_wdata_s;

  assign game_rst_s     = ctrl_q[CTRL_GAME_RST_BIT];
  assign wr_cmd_s       = avs_write && (avs_address == ADDR_CMD);
  assign cmd_ch_s       = avs_writedata[CMD_CH_LSB +: CMD_CH_WIDTH];
  assign unused_wdata_s = ^avs_writedata;

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign game_reset_n = game_reset_n_q;
  assign cmd_valid    = ~fifo_empty_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign pop_s[c] = ~fifo_empty_s[c] & cmd_ready[c];
    // Head is forced to zero while empty so stale storage never leaks out.
    assign cmd_data[c*CMD_WIDTH +: CMD_WIDTH] = fifo_empty_s[c] ? '0 : head_s[c];

    snake_cmd_fifo #(
      .WIDTH (CMD_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (game_rst_s),
      .push      (push_s[c]),
      .push_data (avs_writedata[CMD_WIDTH-1:0]),
      .pop       (pop_s[c]),
      .head      (head_s[c]),
      .empty     (fifo_empty_s[c]),
      .full      (fifo_full_s[c])
    );
  end

  // Command push routing and overflow flags; a new overflow wins over a W1C.
  always_comb begin
    push_s = '0;
    ovf_d  = ovf_q;
    if (avs_write && (avs_address == ADDR_STATUS)) begin
      ovf_d = ovf_q & ~avs_writedata[STATUS_OVF_LSB +: NUM_CH];
    end else begin
      ovf_d = ovf_q;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_cmd_s && !game_rst_s && (cmd_ch_s == CMD_CH_WIDTH'(c))) begin
        if (fifo_full_s[c] && !pop_s[c]) begin
          ovf_d[c] = 1'b1;
        end else begin
          push_s[c] = 1'b1;
        end
      end else begin
        push_s[c] = 1'b0;
      end
    end
  end

  // Pending-change flags: W1C first, then a same-cycle state change re-sets the bit.
  always_comb begin
    pend_d = pend_q;
    if (avs_write && (avs_address == ADDR_IRQ)) begin
      pend_d = pend_q & ~avs_writedata[NUM_CH-1:0];
    end else begin
      pend_d = pend_q;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      // primed_q suppresses the spurious change on the first edge after reset.
      if (primed_q && !game_rst_s &&
          (state_in[c*STATE_WIDTH +: STATE_WIDTH] != state_q[c])) begin
        pend_d[c] = 1'b1;
      end else begin
        pend_d[c] = pend_d[c];
      end
    end
  end

  // CTRL register write.
  always_comb begin
    if (avs_write && (avs_address == ADDR_CTRL)) begin
      ctrl_d = avs_writedata[1:0];
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Read-data multiplexer; unmapped addresses and unused bits return zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (avs_address)
      ADDR_CMD:    rd_mux_s = 32'd0;
      ADDR_STATUS: rd_mux_s = status_word(8'(fifo_empty_s), 8'(fifo_full_s), 8'(ovf_q));
      ADDR_CTRL:   rd_mux_s = {30'd0, ctrl_q};
      ADDR_IRQ:    rd_mux_s = 32'(pend_q);
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (avs_address == (ADDR_STATE0 + 4'(c))) begin
            rd_mux_s = 32'(state_q[c]);
          end else begin
            rd_mux_s = rd_mux_s;
          end
        end
      end
    endcase
  end

  // Control/status registers, registered outputs and state sampling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q          <= '0;
      pend_q         <= '0;
      ctrl_q         <= 2'b00;
      primed_q       <= 1'b0;
      rdata_q        <= 32'd0;
      irq_q          <= 1'b0;
      game_reset_n_q <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= '0;
    end else begin
      ovf_q          <= ovf_d;
      pend_q         <= pend_d;
      ctrl_q         <= ctrl_d;
      primed_q       <= 1'b1;
      irq_q          <= ctrl_q[CTRL_IRQ_EN_BIT] & (|pend_q);
      game_reset_n_q <= ~ctrl_q[CTRL_GAME_RST_BIT];
      if (avs_read) rdata_q <= rd_mux_s;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_in[c*STATE_WIDTH +: STATE_WIDTH];
      end
    end
  end

endmodule
